bootrom_axi_rd_slave: RTL and testbench

AXI4 slave front-end for the 16 KiB boot ROM. It converts AXI4 read bursts into single-port ROM word reads with a fixed 1-cycle read latency. A 2-entry output buffer gives full throughput under RREADY backpressure. Writes are accepted, drained and answered without touching the ROM; it sits between the L2 interconnect and the ROM macro.

---
 rtl/bootrom_axi_pkg.sv | 43 ++++
 rtl/axi_rd_skid_fifo.sv | 55 +++++
 rtl/bootrom_axi_rd_slave.sv | 216 +++++++++++++++++++++
 tb/tb_bootrom_axi_rd_slave.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bootrom_axi_pkg.sv
// Shared constants, FSM state types and burst address stepping for the boot ROM AXI slave.
package bootrom_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    // Address of the following beat; the reserved burst encoding steps like INCR.
    // WRAP assumes a legal power-of-two beat count, so the wrap span is a clean mask.
    function automatic logic [31:0] next_addr(
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input logic [7:0]  len,
        input logic [31:0] addr
    );
        logic [31:0] step;
        logic [31:0] incr;
        logic [31:0] mask;
        step = 32'd1 << size;
        incr = addr + step;
        mask = (({24'd0, len} + 32'd1) * step) - 32'd1;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_skid_fifo.sv
// Two-entry FIFO for read beats {id, data, last}; a push into a full buffer is
// accepted only when a pop happens in the same cycle.
module axi_rd_skid_fifo #(
    parameter int W = 69
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/bootrom_axi_rd_slave.sv
// AXI4 slave front-end for the boot ROM: bursts become 1-cycle-latency ROM word reads.
// Build option BOOTROM_WR_SLVERR_EN answers every write with SLVERR instead of OKAY.
module bootrom_axi_rd_slave #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    output logic                rom_en,
    output logic [ADDR_W-4:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_rdata,
    output logic                dbg_rd_state,
    output logic [1:0]          dbg_wr_state
);

    import bootrom_axi_pkg::*;

    localparam int FW = ID_W + DATA_W + 1;

`ifdef BOOTROM_WR_SLVERR_EN
    localparam logic [1:0] WR_RESP_CODE = RESP_SLVERR;
`else
    localparam logic [1:0] WR_RESP_CODE = RESP_OKAY;
`endif

    // All handshakes are plain AXI valid/ready: a transfer happens on a rising
    // edge where both are high; a source holds its payload stable until then.

    rd_state_t         rd_state;
    rd_state_t         rd_next;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic [7:0]        beats_left;
    logic [31:0]       addr_nxt;
    logic              ar_hs;
    logic              issue;
    logic              last_beat;

    logic              inflight;
    logic              inflight_last;
    logic [ID_W-1:0]   inflight_id;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic              r_pop;

    wr_state_t         wr_state;
    wr_state_t         wr_next;
    logic [ID_W-1:0]   wr_id;
    logic              aw_hs;

    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_pop     = S_AXI_RVALID && S_AXI_RREADY;
    assign last_beat = (beats_left == 8'd0);
    assign addr_nxt  = next_addr(rd_size, rd_burst, rd_len, {{(32-ADDR_W){1'b0}}, rd_addr});

    // A beat may be issued only while buffered plus in-flight beats leave room,
    // or when a pop frees a slot in the same cycle.
    always_comb begin
        rd_next       = rd_state;
        S_AXI_ARREADY = 1'b0;
        issue         = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                S_AXI_ARREADY = !rst;
                if (S_AXI_ARVALID && !rst) rd_next = RD_BURST;
            end
            RD_BURST: begin
                if (((fifo_count + {1'b0, inflight}) < 2'd2) || r_pop) begin
                    issue = 1'b1;
                    if (last_beat) rd_next = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state      <= RD_IDLE;
            rd_id         <= '0;
            rd_addr       <= '0;
            rd_len        <= '0;
            rd_size       <= '0;
            rd_burst      <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_id   <= '0;
        end else begin
            rd_state <= rd_next;
            inflight <= issue;
            if (issue) begin
                inflight_last <= last_beat;
                inflight_id   <= rd_id;
            end
            if (ar_hs) begin
                rd_id      <= S_AXI_ARID;
                rd_addr    <= S_AXI_ARADDR;
                rd_len     <= S_AXI_ARLEN;
                rd_size    <= S_AXI_ARSIZE;
                rd_burst   <= S_AXI_ARBURST;
                beats_left <= S_AXI_ARLEN;
            end else if (issue) begin
                beats_left <= beats_left - 8'd1;
                rd_addr    <= addr_nxt[ADDR_W-1:0];
            end
        end
    end

    assign rom_en   = issue;
    assign rom_addr = rd_addr[ADDR_W-1:3];

    // The beat returning from the ROM is presented directly when the buffer is
    // empty; if it is not taken that cycle it is captured so RDATA stays stable.
    assign fifo_din  = {inflight_id, rom_rdata, inflight_last};
    assign fifo_push = inflight && !(fifo_empty && S_AXI_RREADY);
    assign fifo_pop  = S_AXI_RREADY && !fifo_empty;

    axi_rd_skid_fifo #(
        .W (FW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign S_AXI_RVALID = inflight || !fifo_empty;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign {S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST} =
        !fifo_empty ? fifo_dout : (inflight ? fifo_din : '0);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;

    always_comb begin
        wr_next       = wr_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BRESP   = RESP_OKAY;
        case (wr_state)
            WR_IDLE: begin
                S_AXI_AWREADY = !rst;
                if (S_AXI_AWVALID && !rst) wr_next = WR_DATA;
            end
            WR_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && S_AXI_WLAST) wr_next = WR_RESP;
            end
            WR_RESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = WR_RESP_CODE;
                if (S_AXI_BREADY) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_id    <= '0;
        end else begin
            wr_state <= wr_next;
            if (aw_hs) wr_id <= S_AXI_AWID;
        end
    end

    assign S_AXI_BID    = wr_id;
    assign dbg_rd_state = rd_state;
    assign dbg_wr_state = wr_state;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWADDR, S_AXI_AWLEN, fifo_full, addr_nxt[31:ADDR_W]};

endmodule

// File: tb/tb_bootrom_axi_rd_slave.sv
// Directed bench for bootrom_axi_rd_slave: read bursts, backpressure, writes and reset.
module tb_bootrom_axi_rd_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  S_AXI_ARID = '0;
    logic [13:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic [2:0]  S_AXI_ARSIZE = '0;
    logic [1:0]  S_AXI_ARBURST = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [3:0]  S_AXI_RID;
    logic [63:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [3:0]  S_AXI_AWID = '0;
    logic [13:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic        S_AXI_WLAST = 1'b0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [3:0]  S_AXI_BID;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic        rom_en;
    logic [10:0] rom_addr;
    logic [63:0] rom_rdata = '0;
    logic        dbg_rd_state;
    logic [1:0]  dbg_wr_state;

    int n_total = 0;
    int n_pass  = 0;

`ifdef BOOTROM_WR_SLVERR_EN
    localparam logic [1:0] EXP_BRESP = 2'b10;
`else
    localparam logic [1:0] EXP_BRESP = 2'b00;
`endif

    bootrom_axi_rd_slave dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_ARID    (S_AXI_ARID),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARSIZE  (S_AXI_ARSIZE),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RID     (S_AXI_RID),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .S_AXI_AWID    (S_AXI_AWID),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BID     (S_AXI_BID),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_rdata     (rom_rdata),
        .dbg_rd_state  (dbg_rd_state),
        .dbg_wr_state  (dbg_wr_state)
    );

    // Clock and ROM model: data registered one cycle after rom_en.
    always #5 clk = ~clk;

    function automatic logic [63:0] rom_word(input logic [10:0] a);
        return {32'hB007_C0DE, 21'd0, a};
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_rdata <= rom_word(rom_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Driver: present an AR request (checks are made by the caller).
    task automatic drive_ar(input logic [3:0] id, input logic [13:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        S_AXI_ARID    = id;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARSIZE  = 3'd3;
        S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_total++;
        if ({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, rom_en} !== 6'b0) begin
            $display("FAIL reset_handshakes got=%b exp=000000",
                     {S_AXI_ARREADY, S_AXI_RVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, rom_en});
        end else n_pass++;
        n_total++;
        if ({rom_addr, S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_BRESP} !== 83'd0) begin
            $display("FAIL reset_data got=%h/%h/%h/%h/%h exp=0",
                     rom_addr, S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_BRESP);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({S_AXI_ARREADY, S_AXI_AWREADY, dbg_rd_state, dbg_wr_state} !== 5'b11_0_00) begin
            $display("FAIL reset_release got=%b exp=11000",
                     {S_AXI_ARREADY, S_AXI_AWREADY, dbg_rd_state, dbg_wr_state});
        end else n_pass++;
    endtask

    task automatic test_incr();
        logic [70:0] exp;
        S_AXI_RREADY = 1'b1;
        drive_ar(4'hA, 14'h0100, 8'd3, 2'b01);
        @(negedge clk); S_AXI_ARVALID = 1'b0; #1;
        n_total++;
        if ({rom_en, rom_addr, S_AXI_RVALID} !== {1'b1, 11'h020, 1'b0}) begin
            $display("FAIL incr_first_issue got=%b/%h/%b exp=1/020/0", rom_en, rom_addr, S_AXI_RVALID);
        end else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            exp = {1'b1, (i == 3), 4'hA, rom_word(11'h020 + 11'(i))};
            n_total++;
            if ({S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA} !== exp) begin
                $display("FAIL incr_beat%0d got=%h exp=%h", i,
                         {S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA}, exp);
            end else n_pass++;
            n_total++;
            if (i < 3) begin
                if ({rom_en, rom_addr} !== {1'b1, 11'h021 + 11'(i)}) begin
                    $display("FAIL incr_issue%0d got=%b/%h exp=1/%h", i, rom_en, rom_addr, 11'h021 + 11'(i));
                end else n_pass++;
            end else begin
                if (rom_en !== 1'b0) begin
                    $display("FAIL incr_no_extra_issue got=%b exp=0", rom_en);
                end else n_pass++;
            end
        end
        @(negedge clk); #1;
        n_total++;
        if (S_AXI_RVALID !== 1'b0) begin
            $display("FAIL incr_drained got=%b exp=0", S_AXI_RVALID);
        end else n_pass++;
    endtask

    task automatic test_wrap();
        logic [10:0] exp_addr [4];
        exp_addr[0] = 11'h023; exp_addr[1] = 11'h020; exp_addr[2] = 11'h021; exp_addr[3] = 11'h022;
        S_AXI_RREADY = 1'b1;
        drive_ar(4'h1, 14'h0118, 8'd3, 2'b10);
        @(negedge clk); S_AXI_ARVALID = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({rom_en, rom_addr} !== {1'b1, exp_addr[i]}) begin
                $display("FAIL wrap_addr%0d got=%b/%h exp=1/%h", i, rom_en, rom_addr, exp_addr[i]);
            end else n_pass++;
            @(negedge clk); #1;
            n_total++;
            if ({S_AXI_RVALID, S_AXI_RLAST, S_AXI_RDATA} !== {1'b1, (i == 3), rom_word(exp_addr[i])}) begin
                $display("FAIL wrap_data%0d got=%b/%b/%h exp=1/%b/%h", i, S_AXI_RVALID, S_AXI_RLAST,
                         S_AXI_RDATA, (i == 3), rom_word(exp_addr[i]));
            end else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [64:0] exp_q[$];
        logic [3:0]  pat;
        int          issued;
        int          accepted;
        pat      = 4'b1001;
        issued   = 0;
        accepted = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), rom_word(11'h040 + 11'(i))});
        S_AXI_RREADY = 1'b0;
        drive_ar(4'h6, 14'h0200, 8'd7, 2'b01);
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            S_AXI_ARVALID = 1'b0;
            S_AXI_RREADY  = pat[cyc % 4];
            #1;
            if (rom_en) issued++;
            if (S_AXI_RVALID) begin
                n_total++;
                if ({S_AXI_RLAST, S_AXI_RDATA} !== exp_q[0] || S_AXI_RID !== 4'h6) begin
                    $display("FAIL bp_head got=%b/%h/%h exp=%b/%h/6", S_AXI_RLAST, S_AXI_RDATA,
                             S_AXI_RID, exp_q[0][64], exp_q[0][63:0]);
                end else n_pass++;
                if (S_AXI_RREADY) begin
                    void'(exp_q.pop_front());
                    accepted++;
                end
            end
            n_total++;
            if (issued - accepted > 2) begin
                $display("FAIL bp_outstanding got=%0d exp=<=2", issued - accepted);
            end else n_pass++;
        end
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL bp_all_beats got=%0d_left exp=0_left", exp_q.size());
        end else n_pass++;
        S_AXI_RREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++;
            if ({S_AXI_RVALID, rom_en} !== 2'b00) begin
                $display("FAIL bp_no_dup got=%b exp=00", {S_AXI_RVALID, rom_en});
            end else n_pass++;
        end
        n_total++;
        if (issued != 8) begin
            $display("FAIL bp_issue_count got=%0d exp=8", issued);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        S_AXI_RREADY = 1'b1;
        drive_ar(4'h3, 14'h0008, 8'd0, 2'b01);
        @(negedge clk);
        drive_ar(4'h5, 14'h0010, 8'd0, 2'b01);
        #1;
        n_total++;
        if ({S_AXI_ARREADY, rom_en, rom_addr} !== {1'b0, 1'b1, 11'h001}) begin
            $display("FAIL b2b_first_issue got=%b/%b/%h exp=0/1/001", S_AXI_ARREADY, rom_en, rom_addr);
        end else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA} !== {3'b111, 4'h3, rom_word(11'h001)}) begin
            $display("FAIL b2b_first_resp got=%b/%b/%b/%h/%h exp=1/1/1/3/%h", S_AXI_ARREADY, S_AXI_RVALID,
                     S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA, rom_word(11'h001));
        end else n_pass++;
        @(negedge clk); S_AXI_ARVALID = 1'b0; #1;
        n_total++;
        if ({rom_en, rom_addr, S_AXI_RVALID} !== {1'b1, 11'h002, 1'b0}) begin
            $display("FAIL b2b_second_issue got=%b/%h/%b exp=1/002/0", rom_en, rom_addr, S_AXI_RVALID);
        end else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if ({S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA} !== {2'b11, 4'h5, rom_word(11'h002)}) begin
            $display("FAIL b2b_second_resp got=%b/%b/%h/%h exp=1/1/5/%h", S_AXI_RVALID, S_AXI_RLAST,
                     S_AXI_RID, S_AXI_RDATA, rom_word(11'h002));
        end else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic en_seen;
        en_seen = 1'b0;
        S_AXI_AWID = 4'h9; S_AXI_AWADDR = 14'h0040; S_AXI_AWLEN = 8'd1; S_AXI_AWVALID = 1'b1;
        #1;
        en_seen |= rom_en;
        n_total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b100) begin
            $display("FAIL wr_idle got=%b exp=100", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
        end else n_pass++;
        @(negedge clk);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b1; S_AXI_WLAST = 1'b0;
        #1;
        en_seen |= rom_en;
        n_total++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b010) begin
            $display("FAIL wr_data got=%b exp=010", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
        end else n_pass++;
        @(negedge clk);
        S_AXI_WLAST = 1'b1;
        #1;
        en_seen |= rom_en;
        n_total++;
        if ({S_AXI_WREADY, S_AXI_BVALID} !== 2'b10) begin
            $display("FAIL wr_second_beat got=%b exp=10", {S_AXI_WREADY, S_AXI_BVALID});
        end else n_pass++;
        S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
            #1;
            en_seen |= rom_en;
            n_total++;
            if ({S_AXI_BVALID, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP} !== {2'b10, 4'h9, EXP_BRESP}) begin
                $display("FAIL wr_resp_hold%0d got=%b/%b/%h/%b exp=1/0/9/%b", i, S_AXI_BVALID,
                         S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, EXP_BRESP);
            end else n_pass++;
        end
        S_AXI_BREADY = 1'b1;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        #1;
        en_seen |= rom_en;
        n_total++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, dbg_wr_state} !== 4'b0100) begin
            $display("FAIL wr_done got=%b exp=0100", {S_AXI_BVALID, S_AXI_AWREADY, dbg_wr_state});
        end else n_pass++;
        n_total++;
        if (en_seen !== 1'b0) begin
            $display("FAIL wr_no_rom_en got=%b exp=0", en_seen);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        S_AXI_RREADY = 1'b1;
        drive_ar(4'h7, 14'h0300, 8'd3, 2'b01);
        @(negedge clk); S_AXI_ARVALID = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_total++;
        if ({S_AXI_RVALID, S_AXI_RDATA} !== {1'b1, rom_word(11'h061)}) begin
            $display("FAIL rstmid_beat2 got=%b/%h exp=1/%h", S_AXI_RVALID, S_AXI_RDATA, rom_word(11'h061));
        end else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({S_AXI_RVALID, rom_en, S_AXI_ARREADY, S_AXI_RDATA} !== 67'd0) begin
            $display("FAIL rstmid_drop got=%b/%b/%b/%h exp=0/0/0/0", S_AXI_RVALID, rom_en,
                     S_AXI_ARREADY, S_AXI_RDATA);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++;
        if ({S_AXI_ARREADY, dbg_rd_state, dbg_wr_state} !== 4'b1000) begin
            $display("FAIL rstmid_idle got=%b exp=1000", {S_AXI_ARREADY, dbg_rd_state, dbg_wr_state});
        end else n_pass++;
        drive_ar(4'h2, 14'h0040, 8'd1, 2'b01);
        @(negedge clk); S_AXI_ARVALID = 1'b0; #1;
        n_total++;
        if ({rom_en, rom_addr, S_AXI_RVALID} !== {1'b1, 11'h008, 1'b0}) begin
            $display("FAIL rstmid_fresh_issue got=%b/%h/%b exp=1/008/0", rom_en, rom_addr, S_AXI_RVALID);
        end else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_total++;
            if ({S_AXI_RVALID, S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA} !== {1'b1, (i == 1), 4'h2, rom_word(11'h008 + 11'(i))}) begin
                $display("FAIL rstmid_fresh_beat%0d got=%b/%b/%h/%h exp=1/%b/2/%h", i, S_AXI_RVALID,
                         S_AXI_RLAST, S_AXI_RID, S_AXI_RDATA, (i == 1), rom_word(11'h008 + 11'(i)));
            end else n_pass++;
        end
        @(negedge clk); #1;
        n_total++;
        if (S_AXI_RVALID !== 1'b0) begin
            $display("FAIL rstmid_fresh_end got=%b exp=0", S_AXI_RVALID);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_incr();
        @(negedge clk);
        test_wrap();
        @(negedge clk);
        test_backpressure();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_write();
        @(negedge clk);
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
